rms_frame_buffer: RTL and testbench
===================================

# rms_frame_buffer

Frame buffer that sits directly upstream of the RMS engine. It collects one frame of 8-bit samples from the producer with a ready/valid handshake and clears the RMS accumulator. It then replays the frame as one contiguous `in_valid` burst, so the engine's INPUT state never sees a gap. It waits for the engine's result pulse before accepting the next frame, and reports frame-length and timeout errors on the same `err_data`/`err_valid` convention as the engine.

## Interface
- `DEPTH`, 16: maximum samples per frame (≥2).
- `TIMEOUT`, 1024: cycles allowed from end of burst to `rms_done`. Only used with the watchdog macro.
- `clk` input 1: clock, all flops on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `s_data` input 8: producer sample.
- `s_valid` input 1: producer sample valid.
- `s_last` input 1: marks the final sample of a frame; qualified by `s_valid`.
- `s_ready` output 1: buffer accepts a sample this cycle.
- `out_data` output 8: sample to the RMS engine `in_data`.
- `out_valid` output 1: to the RMS engine `in_valid`.
- `storage_reset` output 1: one-cycle accumulator clear to the RMS engine.
- `rms_rdy` input 1: RMS engine `in_rdy`.
- `rms_done` input 1: RMS engine `out_valid`.
- `err_data` output 2: error code. 01 = length overflow, 10 = timeout, 00/11 unused.
- `err_valid` output 1: one-cycle error strobe.

## Operation
- States: RESET, FILL, WAIT, CLEAR, STREAM, DRAIN.
- Outputs are Moore, decoded from the state register plus counters.

**State behaviour**
- RESET: all outputs 0. Goes to FILL on the first clock edge after `rst` deasserts.
- FILL:
  - `s_ready`=1.
  - On `s_valid`, write `s_data` to `mem[wr_cnt]` and increment `wr_cnt`.
  - If the accepted beat has `s_last`=1, or `wr_cnt` becomes `DEPTH`, latch `len`=`wr_cnt`+1 and go to WAIT.
  - If the frame closed at `DEPTH` without `s_last`: pulse `err_valid` with `err_data`=01. The frame is still processed. The producer's remaining beats form the next frame.
- WAIT: `s_ready`=0. Goes to CLEAR when `rms_rdy`=1.
- CLEAR: `storage_reset`=1 for exactly one cycle, `out_valid`=0. Goes to STREAM.
- STREAM:
  - `out_valid`=1 and `out_data`=`mem[rd_cnt]`. `rd_cnt` runs 0..`len`-1, one sample per cycle with no stalls.
  - After the beat at `rd_cnt`=`len`-1, go to DRAIN.
- DRAIN:
  - `out_valid`=0. Wait for `rms_done`=1, then go to FILL and clear `wr_cnt`/`rd_cnt`.

**Width and boundary rules**
- Counters are `$clog2(DEPTH+1)` bits. `len` ranges 1..`DEPTH`.
- A single-sample frame (`s_last` on the first beat) gives `len`=1 and a one-cycle burst.
- Memory contents are not cleared at reset; `len` gates all reads.
- `rms_done` outside DRAIN is ignored.
- `s_valid` while `s_ready`=0 is backpressure, not an error.
- When `rst` is asserted mid-operation, all state, counters and outputs clear asynchronously. The partial frame is discarded.

## Timing
- Reset values: `s_ready`=0, `out_valid`=0, `out_data`=0, `storage_reset`=0, `err_valid`=0, `err_data`=00.
- Last sample accepted at cycle t → WAIT at t+1.
- If `rms_rdy`=1 at t+1: `storage_reset` at t+2, `out_valid` high t+3..t+2+`len`, DRAIN from t+3+`len`.
- `rms_done` at cycle d → FILL (`s_ready`=1) at d+1.
- `err_valid` is high in the cycle after the closing beat, i.e. the first WAIT cycle.
- `storage_reset` and `out_valid` are never high in the same cycle.

## Configuration
- `RMS_FRAME_TIMEOUT_EN` defined:
  - DRAIN runs a down-counter loaded with `TIMEOUT` on entry.
  - At zero without `rms_done`, pulse `err_valid` with `err_data`=10 and go to FILL.
  - `rms_done` in the same cycle the counter reaches zero counts as success, with no error.
- Not defined: no counter; DRAIN waits indefinitely and code 10 is never produced.

## Structure
- Shared package `rms_pkg`:
  - state enum;
  - error code constants (`ERR_NONE`, `ERR_LEN`, `ERR_TIMEOUT`);
  - sample width constant 8.
- Sub-module `rms_frame_mem`: `DEPTH`×8 register array, one synchronous write port, one asynchronous read port.
- The FSM, counters and watchdog live in the top-level block.

## Test plan
- Frame of 4 samples {3,4,0,0} with `s_last` on the 4th, `rms_rdy`=1 → one `storage_reset` pulse, then exactly 4 consecutive `out_valid` cycles carrying 3,4,0,0, then `s_ready` stays 0 until `rms_done`.
- 20 samples without `s_last`, `DEPTH`=16 → burst of 16, `err_data`=01 pulsed once. The remaining 4 samples form the next frame after `rms_done`.
- Single sample 255 with `s_last` → `storage_reset`, then 1-cycle burst carrying 255.
- `rms_rdy` held 0 for 50 cycles after the frame closes → no `storage_reset`/`out_valid` until `rms_rdy` rises, `s_ready`=0 throughout.
- With `RMS_FRAME_TIMEOUT_EN`, `TIMEOUT`=8 and `rms_done` never asserted → `err_data`=10 strobe 8 cycles after the burst ends, then `s_ready`=1.
- `rst` pulled low mid-STREAM → `out_valid`=0 immediately. After release, one RESET cycle, then FILL with `wr_cnt`=0.

Source files
------------

// File: rtl/rms_pkg.sv
// rms_pkg: shared states, error codes and sample width for the RMS frame buffer.
package rms_pkg;

    localparam int SAMPLE_W = 8;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FILL,
        ST_WAIT,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/rms_frame_buffer_if.sv
// rms_frame_buffer_if: producer stream plus RMS-engine side of the frame buffer.
interface rms_frame_buffer_if;
    import rms_pkg::*;

    logic [SAMPLE_W-1:0] s_data;
    logic                s_valid;
    logic                s_last;
    logic                s_ready;
    logic [SAMPLE_W-1:0] out_data;
    logic                out_valid;
    logic                storage_reset;
    logic                rms_rdy;
    logic                rms_done;
    logic [1:0]          err_data;
    logic                err_valid;

    modport master (
        output s_data, s_valid, s_last, rms_rdy, rms_done,
        input  s_ready, out_data, out_valid, storage_reset, err_data, err_valid
    );

    modport slave (
        input  s_data, s_valid, s_last, rms_rdy, rms_done,
        output s_ready, out_data, out_valid, storage_reset, err_data, err_valid
    );

endinterface

// File: rtl/rms_frame_mem.sv
// rms_frame_mem: DEPTH x SAMPLE_W register array, sync write, async read.
module rms_frame_mem
    import rms_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [SAMPLE_W-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [SAMPLE_W-1:0] rdata
);

    logic [SAMPLE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rms_frame_buffer.sv
// rms_frame_buffer: collects one frame, replays it as a gap-free burst to the RMS engine.
// Define RMS_FRAME_TIMEOUT_EN to add the DRAIN watchdog (err_data 10 after TIMEOUT cycles).
module rms_frame_buffer
    import rms_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    rms_frame_buffer_if.slave  bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    state_t              state_q, state_d;
    logic [CW-1:0]       wr_q, wr_d, rd_q, rd_d, len_q, len_d;
    logic [1:0]          err_q, err_d;
    logic [SAMPLE_W-1:0] rdata;
    logic                expired;

    rms_frame_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (state_q == ST_FILL && bus.s_valid),
        .waddr (wr_q[AW-1:0]),
        .wdata (bus.s_data),
        .raddr (rd_q[AW-1:0]),
        .rdata (rdata)
    );

`ifdef RMS_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    assign expired = tmo_q == '0;
    // Held at TIMEOUT outside DRAIN, so it is already loaded on entry.
    always_comb tmo_d = (state_q != ST_DRAIN) ? TW'(TIMEOUT) : (expired ? tmo_q : tmo_q - 1'b1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmo_q <= '0;
        else      tmo_q <= tmo_d;
    end
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        len_d   = len_q;
        err_d   = ERR_NONE;
        case (state_q)
            ST_RESET: state_d = ST_FILL;
            ST_FILL: begin
                if (bus.s_valid) begin
                    wr_d = wr_q + 1'b1;
                    if (bus.s_last || wr_d == CW'(DEPTH)) begin
                        len_d   = wr_d;
                        state_d = ST_WAIT;
                        err_d   = bus.s_last ? ERR_NONE : ERR_LEN;
                    end
                end
            end
            ST_WAIT:  state_d = bus.rms_rdy ? ST_CLEAR : ST_WAIT;
            ST_CLEAR: state_d = ST_STREAM;
            ST_STREAM: begin
                rd_d    = rd_q + 1'b1;
                state_d = (rd_q == len_q - 1'b1) ? ST_DRAIN : ST_STREAM;
            end
            ST_DRAIN: begin
                if (bus.rms_done || expired) begin
                    state_d = ST_FILL;
                    wr_d    = '0;
                    rd_d    = '0;
                    err_d   = bus.rms_done ? ERR_NONE : ERR_TIMEOUT;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RESET;
            wr_q    <= '0;
            rd_q    <= '0;
            len_q   <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign bus.s_ready       = state_q == ST_FILL;
    assign bus.storage_reset = state_q == ST_CLEAR;
    assign bus.out_valid     = state_q == ST_STREAM;
    assign bus.out_data      = (state_q == ST_STREAM) ? rdata : '0;
    assign bus.err_data      = err_q;
    assign bus.err_valid     = err_q != ERR_NONE;

endmodule

// File: tb/tb_rms_frame_buffer.sv
// tb_rms_frame_buffer: scoreboard bench; stimulus pushes expected events, a monitor pops them.
module tb_rms_frame_buffer;
    import rms_pkg::*;

    localparam int K_CLR = 0, K_SMP = 1, K_ERR = 2;

    typedef struct {
        int kind;
        int data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   auto_done = 1'b1;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    int   len_q[$];

    rms_frame_buffer_if bus ();

    rms_frame_buffer #(.DEPTH(16), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic push(input int k, input int d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int k, input int d, input string nm);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event kind %0d data %0d", nm, k, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data != d) begin
                errors++;
                $display("FAIL %s: got kind %0d data %0d expected kind %0d data %0d", nm, k, d, e.kind, e.data);
            end
        end
    endtask

    // Monitor: every DUT output event is compared against the scoreboard.
    int run = 0;
    always @(negedge clk) begin
        if (!rst) begin
            run = 0;
        end else begin
            if (bus.storage_reset) begin
                check_ev(K_CLR, 0, "storage_reset");
                chk("clr_exclusive", int'(bus.out_valid || bus.s_ready), 0);
            end
            if (bus.out_valid) begin
                check_ev(K_SMP, int'(bus.out_data), "sample");
                chk("s_ready_in_burst", int'(bus.s_ready), 0);
                run++;
            end else if (run != 0) begin
                if (len_q.size() == 0) chk("burst_len_unexpected", run, 0);
                else chk("burst_len", run, len_q.pop_front());
                run = 0;
            end
            if (bus.err_valid) check_ev(K_ERR, int'(bus.err_data), "err");
        end
    end

    // Engine model: pulses rms_done a few cycles after each burst ends.
    bit prev_ov = 1'b0;
    initial begin
        bus.rms_done = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_ov && !bus.out_valid && rst && auto_done) begin
                repeat (3) @(negedge clk);
                chk("drain_s_ready", int'(bus.s_ready), 0);
                bus.rms_done = 1'b1;
                @(negedge clk);
                bus.rms_done = 1'b0;
                chk("fill_after_done", int'(bus.s_ready), 1);
            end
            prev_ov = bus.out_valid;
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        bus.s_last  = l;
        while (!bus.s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("send_timeout", n, 0);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !bus.s_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("idle_timeout", n, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.rms_rdy = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", int'(bus.s_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_storage_reset", int'(bus.storage_reset), 0);
        chk("rst_err", int'({bus.err_valid, bus.err_data}), 0);
        rst = 1'b1;
        chk("reset_cycle", int'(bus.s_ready), 0);
        @(negedge clk);
        chk("fill_after_reset", int'(bus.s_ready), 1);

        // Frame {3,4,0,0}
        push(K_CLR, 0); push(K_SMP, 3); push(K_SMP, 4); push(K_SMP, 0); push(K_SMP, 0);
        len_q.push_back(4);
        send(8'd3, 1'b0); send(8'd4, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b1);
        wait_idle();

        // 20 beats: first 16 overflow, last 4 form the next frame
        push(K_ERR, int'(ERR_LEN)); push(K_CLR, 0);
        for (int i = 0; i < 16; i++) push(K_SMP, i * 7 + 1);
        len_q.push_back(16);
        push(K_CLR, 0);
        for (int i = 16; i < 20; i++) push(K_SMP, i * 7 + 1);
        len_q.push_back(4);
        for (int i = 0; i < 20; i++) send(8'(i * 7 + 1), i == 19);
        wait_idle();

        // Single sample
        push(K_CLR, 0); push(K_SMP, 255);
        len_q.push_back(1);
        send(8'd255, 1'b1);
        wait_idle();

        // rms_rdy held low after the frame closes
        bus.rms_rdy = 1'b0;
        push(K_CLR, 0); push(K_SMP, 10); push(K_SMP, 20);
        len_q.push_back(2);
        send(8'd10, 1'b0); send(8'd20, 1'b1);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.s_ready || bus.out_valid || bus.storage_reset) n++;
            @(negedge clk);
        end
        chk("rdy_low_quiet", n, 0);
        bus.rms_rdy = 1'b1;
        wait_idle();

        // Reset mid-STREAM
        push(K_CLR, 0);
        for (int i = 1; i <= 8; i++) push(K_SMP, i);
        len_q.push_back(8);
        for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stream_started", int'(bus.out_valid), 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_out_valid", int'(bus.out_valid), 0);
        chk("async_rst_s_ready", int'(bus.s_ready), 0);
        exp_q.delete();
        len_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("reset_cycle2", int'(bus.s_ready), 0);
        @(negedge clk);
        chk("fill_after_reset2", int'(bus.s_ready), 1);
        push(K_CLR, 0); push(K_SMP, 8'h11); push(K_SMP, 8'h22);
        len_q.push_back(2);
        send(8'h11, 1'b0); send(8'h22, 1'b1);
        wait_idle();

`ifdef RMS_FRAME_TIMEOUT_EN
        auto_done = 1'b0;
        push(K_CLR, 0); push(K_SMP, 7); push(K_ERR, int'(ERR_TIMEOUT));
        len_q.push_back(1);
        send(8'd7, 1'b1);
        wait_idle();
        repeat (2) @(negedge clk);
        auto_done = 1'b1;
`endif

        repeat (3) @(negedge clk);
        chk("queues_drained", exp_q.size() + len_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
